// File: rtl/crc_pkg.sv
// Shared CRC-8 link definitions: receiver FSM states, default polynomial and the
// single-bit LFSR step used by both ends of the link.
package crc_pkg;

  localparam int         CRC_MAX_W    = 32;
  localparam int         CRC_IDX_W    = $clog2(CRC_MAX_W);
  localparam logic [7:0] CRC_SEED_DEF = 8'hD8;
  localparam logic [7:0] CRC_TAPS_DEF = 8'b0100_0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX_DATA,
    S_WAIT_CRC,
    S_RX_CRC
  } state_e;

  // Feeds one payload bit into the LFSR; only the low 'width' bits are meaningful.
  function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] lfsr,
                                                    input logic                 d,
                                                    input logic [CRC_MAX_W-1:0] taps,
                                                    input int                   width);
    logic                 fb;
    logic [CRC_MAX_W-1:0] nxt;
    fb  = d ^ lfsr[0];
    nxt = '0;
    for (int i = 0; i < CRC_MAX_W - 1; i++) begin
      if (i < width - 1) begin
        nxt[i] = taps[i] ? (lfsr[i+1] ^ fb) : lfsr[i+1];
      end
    end
    nxt[CRC_IDX_W'(width - 1)] = fb;
    return nxt;
  endfunction

endpackage

// File: rtl/crc_checker_if.sv
// Receive-side bus of the serial CRC link: line and qualifiers in, payload and status out.
interface crc_checker_if #(
  parameter int DATA_BITS = 8
);
  logic                 DATA;
  logic                 ACTIVE;
  logic                 CRC_VALID;
  logic [DATA_BITS-1:0] DATA_OUT;
  logic                 DONE;
  logic                 ERR;
  logic                 FRAME_ERR;
  logic                 BUSY;

  modport master (
    output DATA, ACTIVE, CRC_VALID,
    input  DATA_OUT, DONE, ERR, FRAME_ERR, BUSY
  );

  modport slave (
    input  DATA, ACTIVE, CRC_VALID,
    output DATA_OUT, DONE, ERR, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/crc_lfsr.sv
// CRC LFSR: seed load, payload step (optionally from the seed) and right shift
// with zero fill so the check bits can be read out LSB first.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = CRC_SEED_DEF,
  parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic load_i,
  input  logic step_i,
  input  logic shift_i,
  input  logic bit_i,
  output logic out_bit_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Step takes priority; with load_i also set it starts from SEED (frame start).
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = WIDTH'(crc_step(CRC_MAX_W'(load_i ? SEED : lfsr_q), bit_i,
                               CRC_MAX_W'(TAPS), WIDTH));
    end else if (shift_i) begin
      lfsr_d = lfsr_q >> 1;
    end else if (load_i) begin
      lfsr_d = SEED;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_bit_o = lfsr_q[0];

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 receive checker: deserialises the payload, regenerates the LFSR,
// compares the trailing check bits and flags CRC and framing errors.
module crc_checker
  import crc_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_SEED_DEF,
  parameter logic [CRC_WIDTH-1:0] TAPS      = CRC_TAPS_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  crc_checker_if.slave  bus
);

  localparam int               MAX_BITS     = (DATA_BITS > CRC_WIDTH) ? DATA_BITS : CRC_WIDTH;
  localparam int               CNT_W        = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_DATA     = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_CRC_LAST = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] pay_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 mis_q;
  logic                 done_q;
  logic                 err_q;
  logic                 frame_err_q;
  logic                 busy_q;

  logic data_full;
  logic rx_abort;
  logic abort;
  logic first_chk;
  logic lfsr_load;
  logic lfsr_step;
  logic lfsr_shift;
  logic lfsr_bit;
  logic bit_mis;

  assign data_full = (cnt_q == CNT_DATA);
  // In RX_DATA only "another payload bit" or "payload complete, line idle or first check bit" is legal.
  assign rx_abort  = bus.ACTIVE ? (bus.CRC_VALID || data_full) : !data_full;

  always_comb begin
    abort = 1'b0;
    unique case (state_q)
      S_IDLE:     abort = bus.CRC_VALID && !bus.ACTIVE;
      S_RX_DATA:  abort = rx_abort;
      S_WAIT_CRC: abort = bus.ACTIVE;
      S_RX_CRC:   abort = bus.ACTIVE || !bus.CRC_VALID;
      default:    abort = 1'b0;
    endcase
  end

  assign first_chk  = bus.CRC_VALID && !bus.ACTIVE &&
                      ((state_q == S_WAIT_CRC) || (state_q == S_RX_DATA && data_full));
  assign lfsr_load  = (state_q == S_IDLE);
  assign lfsr_step  = bus.ACTIVE && ((state_q == S_IDLE) || (state_q == S_RX_DATA && !rx_abort));
  assign lfsr_shift = first_chk || (state_q == S_RX_CRC && !abort);
  assign bit_mis    = bus.DATA ^ lfsr_bit;

  crc_lfsr #(
    .WIDTH (CRC_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (lfsr_load),
    .step_i    (lfsr_step),
    .shift_i   (lfsr_shift),
    .bit_i     (bus.DATA),
    .out_bit_o (lfsr_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pay_q       <= '0;
      data_out_q  <= '0;
      mis_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (abort) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.ACTIVE) begin
              pay_q   <= {bus.DATA, pay_q[DATA_BITS-1:1]};
              cnt_q   <= CNT_ONE;
              state_q <= S_RX_DATA;
              busy_q  <= 1'b1;
            end
          end
          S_RX_DATA: begin
            if (bus.ACTIVE) begin
              pay_q <= {bus.DATA, pay_q[DATA_BITS-1:1]};
              cnt_q <= cnt_q + CNT_ONE;
            end else if (bus.CRC_VALID) begin
              mis_q   <= bit_mis;
              cnt_q   <= CNT_ONE;
              state_q <= S_RX_CRC;
            end else begin
              cnt_q   <= '0;
              state_q <= S_WAIT_CRC;
            end
          end
          S_WAIT_CRC: begin
            if (bus.CRC_VALID) begin
              mis_q   <= bit_mis;
              cnt_q   <= CNT_ONE;
              state_q <= S_RX_CRC;
            end
          end
          S_RX_CRC: begin
            if (cnt_q == CNT_CRC_LAST) begin
              done_q     <= 1'b1;
              err_q      <= mis_q | bit_mis;
              data_out_q <= pay_q;
              cnt_q      <= '0;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
            end else begin
              mis_q <= mis_q | bit_mis;
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DATA_OUT  = data_out_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed, random and framing-error frames
// scored against an expected-event queue filled as stimulus is driven.
module tb_crc_checker;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t ev;
  logic [7:0] last_data = 8'h00;
  logic       last_err  = 1'b0;

  always #5 clk = ~clk;

  crc_checker_if #(.DATA_BITS(8)) bus ();

  crc_checker #(
    .DATA_BITS (8),
    .CRC_WIDTH (8),
    .SEED      (8'hD8),
    .TAPS      (8'b0100_0100)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: reflected Galois form, feedback constant = top bit | tap mask.
  function automatic logic [7:0] model_crc(input logic [7:0] p);
    logic [7:0] r;
    logic       fb;
    r = 8'hD8;
    for (int i = 0; i < 8; i++) begin
      fb = p[i] ^ r[0];
      r  = (r >> 1) ^ (fb ? 8'hC4 : 8'h00);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ACTIVE    = 1'b0;
      bus.CRC_VALID = 1'b0;
      bus.DATA      = 1'($urandom);
      tick();
    end
  endtask

  task automatic push_done(input logic [7:0] p, input logic e);
    sb_q.push_back('{is_ferr: 1'b0, data: p, err: e});
    last_data = p;
    last_err  = e;
  endtask

  task automatic push_ferr();
    sb_q.push_back('{is_ferr: 1'b1, data: last_data, err: last_err});
  endtask

  task automatic drive_payload(input logic [7:0] p, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.ACTIVE    = 1'b1;
      bus.CRC_VALID = 1'b0;
      bus.DATA      = p[i];
      tick();
    end
    bus.ACTIVE = 1'b0;
  endtask

  task automatic drive_crc(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.ACTIVE    = 1'b0;
      bus.CRC_VALID = 1'b1;
      bus.DATA      = c[i];
      tick();
    end
    bus.CRC_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p, input logic [7:0] c, input int gap, input logic exp_err);
    push_done(p, exp_err);
    drive_payload(p, 8);
    idle(gap);
    drive_crc(c, 8);
    // last check bit was sampled at the edge just passed: DONE must be up now
    chk("done_latency", 32'(bus.DONE), 32'd1);
    chk("busy_after_done", 32'(bus.BUSY), 32'd0);
  endtask

  // The violating input has been driven; the next edge must drop the frame.
  task automatic expect_abort(input string tag);
    tick();
    chk({tag, "_frame_err"}, 32'(bus.FRAME_ERR), 32'd1);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    bus.ACTIVE    = 1'b0;
    bus.CRC_VALID = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.DONE || bus.FRAME_ERR)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", {30'd0, bus.DONE, bus.FRAME_ERR}, 32'd0);
      end else begin
        ev = sb_q.pop_front();
        $display("event %s data_out=%02h err=%0b", bus.DONE ? "DONE" : "FRAME_ERR", bus.DATA_OUT, bus.ERR);
        chk("event_kind", {30'd0, bus.DONE, bus.FRAME_ERR}, ev.is_ferr ? 32'd1 : 32'd2);
        chk("data_out", 32'(bus.DATA_OUT), 32'(ev.data));
        chk("err", 32'(bus.ERR), 32'(ev.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    logic [7:0] c;
    int         gap;

    bus.DATA      = 1'b0;
    bus.ACTIVE    = 1'b0;
    bus.CRC_VALID = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(bus.DATA_OUT), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_frame_err", 32'(bus.FRAME_ERR), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    #3 rst_n = 1'b1;
    idle(2);

    // Directed: all-zero payload with its known check byte, then one check bit flipped
    send_frame(8'h00, 8'h14, 0, 1'b0);
    idle(1);
    send_frame(8'h00, 8'h1C, 0, 1'b1);
    idle(2);

    // Random payloads, alternating zero and three idle cycles between phases
    for (int k = 0; k < 10; k++) begin
      p   = 8'($urandom_range(255));
      c   = model_crc(p);
      gap = (k % 2 == 1) ? 3 : 0;
      $display("frame %0d payload=%02h crc=%02h gap=%0d", k, p, c, gap);
      send_frame(p, c, gap, 1'b0);
      idle(gap);
    end

    // Short payload: ACTIVE drops after 5 bits
    push_ferr();
    drive_payload(8'h5A, 5);
    bus.CRC_VALID = 1'b0;
    expect_abort("short_payload");
    idle(2);
    send_frame(8'h3C, model_crc(8'h3C), 0, 1'b0);
    idle(2);

    // CRC_VALID drops after 4 check bits
    push_ferr();
    drive_payload(8'hC3, 8);
    drive_crc(model_crc(8'hC3), 4);
    expect_abort("short_crc");
    idle(2);

    // ACTIVE reasserted while waiting for the check bits
    push_ferr();
    drive_payload(8'h96, 8);
    idle(2);
    bus.ACTIVE = 1'b1;
    bus.DATA   = 1'b1;
    expect_abort("active_in_wait");
    idle(2);

    // Asynchronous reset while check bit 2 is on the line
    drive_payload(8'h77, 8);
    drive_crc(model_crc(8'h77), 2);
    c             = model_crc(8'h77);
    bus.CRC_VALID = 1'b1;
    bus.DATA      = c[2];
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data_out", 32'(bus.DATA_OUT), 32'd0);
    chk("async_rst_busy", 32'(bus.BUSY), 32'd0);
    chk("async_rst_done", 32'(bus.DONE), 32'd0);
    chk("async_rst_err", 32'(bus.ERR), 32'd0);
    bus.CRC_VALID = 1'b0;
    last_data     = 8'h00;
    last_err      = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(2);
    chk("post_rst_done", 32'(bus.DONE), 32'd0);
    send_frame(8'hA5, model_crc(8'hA5), 0, 1'b0);
    idle(3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
